// File: rtl/burst_data.sv
// rtl/burst_data.sv - CAS-to-data-bus burst scheduler with latency countdown FIFO
module burst_data #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clock_t,
    input  logic              reset_n,
    input  logic              cas_rdy,
    input  logic [1:0]        cas_rw,
    input  logic [4:0]        CL,
    input  logic [4:0]        CWL,
    input  logic [4:0]        BL,
    input  logic [DATA_W-1:0] dq_in,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] dq_out,
    output logic              dq_oe,
    output logic              wr_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rw_done,
    output logic              busy,
    output logic              cmd_ovf,
    output logic              bus_err
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        DATA_IDLE,
        DATA_WAIT,
        DATA_XFER
    } state_t;

    state_t state, state_nxt;

    // Entry 0 is the head; slot DEPTH is a permanently empty spare so the
    // shift-down on retire never reads past the array.
    logic [4:0] e_cnt  [0:DEPTH];
    logic [4:0] e_half [0:DEPTH];
    logic       e_wr   [0:DEPTH];

    logic [CW-1:0] count;
    logic [CW-1:0] wr_idx;
    logic [4:0]    beat;
    logic [4:0]    lat;
    logic          legal;
    logic          accept;
    logic          xfer_last;
    logic          final_idle;
    logic          rd_pend;

    function automatic logic [4:0] sat_dec(input logic [4:0] v);
        return (v == 5'd0) ? 5'd0 : v - 5'd1;
    endfunction

    assign legal     = (cas_rw == 2'b01) || (cas_rw == 2'b10);
    assign xfer_last = (state == DATA_XFER) && (beat == e_half[0] - 5'd1);
    assign accept    = cas_rdy && legal && ((count != CW'(DEPTH)) || xfer_last);
    assign lat       = (cas_rw == 2'b01) ? CL : CWL;
    assign wr_idx    = xfer_last ? count - CW'(1) : count;
    // Last beat of the last queued burst with nothing arriving behind it.
    assign final_idle = xfer_last && (count == CW'(1)) && !accept;

    assign dq_oe  = (state == DATA_XFER) && e_wr[0];
    assign wr_ack = dq_oe;
    assign dq_out = dq_oe ? wr_data : '0;
    assign busy   = (state != DATA_IDLE) || (count != '0);

    // State register.
    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            state <= DATA_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: countdown values of 1 mean the first beat is on the next cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            DATA_IDLE: begin
                if (accept) begin
                    state_nxt = DATA_WAIT;
                end
            end
            DATA_WAIT: begin
                if (e_cnt[0] <= 5'd1) begin
                    state_nxt = DATA_XFER;
                end
            end
            DATA_XFER: begin
                if (xfer_last) begin
                    if ((count > CW'(1)) && (e_cnt[1] <= 5'd1)) begin
                        state_nxt = DATA_XFER;
                    end else if ((count > CW'(1)) || accept) begin
                        state_nxt = DATA_WAIT;
                    end else begin
                        state_nxt = DATA_IDLE;
                    end
                end
            end
            default: state_nxt = DATA_IDLE;
        endcase
    end

    // Beat counter within the current burst; restarts on every burst entry.
    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            beat <= '0;
        end else if ((state == DATA_XFER) && !xfer_last) begin
            beat <= beat + 5'd1;
        end else begin
            beat <= '0;
        end
    end

    // Command FIFO: age every countdown, shift on retire, append on accept.
    // The accept cycle itself counts, so the stored countdown is latency-1.
    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i <= DEPTH; i++) begin
                e_cnt[i]  <= '0;
                e_half[i] <= '0;
                e_wr[i]   <= 1'b0;
            end
            count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (xfer_last) begin
                    e_cnt[i]  <= sat_dec(e_cnt[i+1]);
                    e_half[i] <= e_half[i+1];
                    e_wr[i]   <= e_wr[i+1];
                end else begin
                    e_cnt[i] <= sat_dec(e_cnt[i]);
                end
            end
            if (accept) begin
                e_cnt[wr_idx]  <= lat - 5'd1;
                e_half[wr_idx] <= BL >> 1;
                e_wr[wr_idx]   <= (cas_rw == 2'b10);
            end
            count <= count + CW'(accept) - CW'(xfer_last);
        end
    end

    // Read capture, completion pulse and sticky error flags. Read completion
    // waits one extra cycle so it follows the last registered rd_valid.
    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_pend  <= 1'b0;
            rw_done  <= 1'b0;
            cmd_ovf  <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            rd_valid <= (state == DATA_XFER) && !e_wr[0];
            if ((state == DATA_XFER) && !e_wr[0]) begin
                rd_data <= dq_in;
            end
            rd_pend <= final_idle && !e_wr[0];
            rw_done <= (final_idle && e_wr[0]) || rd_pend;
            if (cas_rdy && legal && !accept) begin
                cmd_ovf <= 1'b1;
            end
            if ((state == DATA_XFER) && (count > CW'(1)) && (e_cnt[1] == 5'd0)) begin
                bus_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_burst_data.sv
// tb/tb_burst_data.sv - scoreboard bench for burst_data
module tb_burst_data;

    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic          clock_t = 1'b0;
    logic          reset_n = 1'b1;
    logic          cas_rdy = 1'b0;
    logic [1:0]    cas_rw  = 2'b00;
    logic [4:0]    CL      = 5'd11;
    logic [4:0]    CWL     = 5'd9;
    logic [4:0]    BL      = 5'd8;
    logic [DW-1:0] dq_in   = '0;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] dq_out;
    logic [DW-1:0] rd_data;
    logic          dq_oe, wr_ack, rd_valid, rw_done, busy, cmd_ovf, bus_err;

    burst_data #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clock_t (clock_t),
        .reset_n (reset_n),
        .cas_rdy (cas_rdy),
        .cas_rw  (cas_rw),
        .CL      (CL),
        .CWL     (CWL),
        .BL      (BL),
        .dq_in   (dq_in),
        .wr_data (wr_data),
        .dq_out  (dq_out),
        .dq_oe   (dq_oe),
        .wr_ack  (wr_ack),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .rw_done (rw_done),
        .busy    (busy),
        .cmd_ovf (cmd_ovf),
        .bus_err (bus_err)
    );

    always #5 clock_t = ~clock_t;

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } beat_t;

    beat_t rd_q[$];
    beat_t wr_q[$];
    int    done_q[$];
    int    finals[$];
    int    cyc, errors, checks, rd_seen;
    int    bus_free, wr_exp, last_final;
    logic  exp_ovf, exp_berr;
    int    wr_ptr;

    function automatic logic [15:0] rpat(input int c);
        return 16'(c * 257 + 15450);
    endfunction

    function automatic logic [15:0] wpat(input int k);
        return 16'(k * 7 + 40960);
    endfunction

    // Upstream write buffer: advances one word per acknowledged beat.
    always @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) wr_ptr <= 0;
        else if (wr_ack) wr_ptr <= wr_ptr + 1;
    end
    assign wr_data = wpat(wr_ptr);

    task automatic clear_model();
        rd_q.delete(); wr_q.delete(); done_q.delete(); finals.delete();
        bus_free = 0; wr_exp = 0; last_final = -100;
        exp_ovf = 1'b0; exp_berr = 1'b0;
    endtask

    // One clock: compare outputs of the current cycle at the falling edge,
    // then step to just after the next rising edge.
    task automatic tick();
        beat_t e;
        int    d;
        @(negedge clock_t);
        while (rd_q.size() != 0 && rd_q[0].cyc < cyc) begin
            e = rd_q.pop_front(); checks++; errors++;
            $display("FAIL rd_missing: no rd_valid at cycle %0d, required data %h", e.cyc, e.data);
        end
        if (rd_valid === 1'b1) begin
            checks++; rd_seen++;
            if (rd_q.size() == 0) begin
                errors++; $display("FAIL rd_unexpected: rd_valid=1 at cycle %0d, required 0", cyc);
            end else begin
                e = rd_q.pop_front();
                if (e.cyc != cyc || rd_data !== e.data) begin
                    errors++;
                    $display("FAIL rd_beat: cycle %0d data %h, required cycle %0d data %h", cyc, rd_data, e.cyc, e.data);
                end
            end
        end
        while (wr_q.size() != 0 && wr_q[0].cyc < cyc) begin
            e = wr_q.pop_front(); checks++; errors++;
            $display("FAIL wr_missing: no dq_oe at cycle %0d, required data %h", e.cyc, e.data);
        end
        checks++;
        if (dq_oe === 1'b1) begin
            if (wr_q.size() == 0) begin
                errors++; $display("FAIL wr_unexpected: dq_oe=1 at cycle %0d, required 0", cyc);
            end else begin
                e = wr_q.pop_front();
                if (e.cyc != cyc || dq_out !== e.data || wr_ack !== 1'b1) begin
                    errors++;
                    $display("FAIL wr_beat: cycle %0d dq_out %h wr_ack %b, required cycle %0d dq_out %h wr_ack 1", cyc, dq_out, wr_ack, e.cyc, e.data);
                end
            end
        end else if (dq_out !== '0 || wr_ack !== 1'b0) begin
            errors++;
            $display("FAIL bus_idle: cycle %0d dq_out %h wr_ack %b, required 0 0", cyc, dq_out, wr_ack);
        end
        while (done_q.size() != 0 && done_q[0] < cyc) begin
            d = done_q.pop_front(); checks++; errors++;
            $display("FAIL done_missing: no rw_done at cycle %0d", d);
        end
        if (rw_done === 1'b1) begin
            checks++;
            if (done_q.size() == 0) begin
                errors++; $display("FAIL done_unexpected: rw_done=1 at cycle %0d, required 0", cyc);
            end else begin
                d = done_q.pop_front();
                if (d != cyc) begin
                    errors++; $display("FAIL done_cycle: rw_done at cycle %0d, required cycle %0d", cyc, d);
                end
            end
        end
        @(posedge clock_t);
        #1;
        cyc++;
        dq_in = rpat(cyc);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    // Drive one CAS pulse in the current cycle and predict its bus activity.
    task automatic issue(input logic [1:0] rw, input int lat, input int bl);
        int t, des, start, half, occ;
        t = cyc;
        cas_rdy = 1'b1; cas_rw = rw; BL = 5'(bl);
        if (rw == 2'b01) CL = 5'(lat); else CWL = 5'(lat);
        if (rw == 2'b01 || rw == 2'b10) begin
            occ = 0;
            foreach (finals[i]) if (finals[i] > t) occ++;
            if (occ >= DEPTH) begin
                exp_ovf = 1'b1;
            end else begin
                half = bl / 2;
                des = t + lat;
                start = des;
                if (bus_free > des) begin
                    start = bus_free;
                    exp_berr = 1'b1;
                end
                if (done_q.size() != 0 && last_final >= t) void'(done_q.pop_back());
                for (int k = 0; k < half; k++) begin
                    if (rw == 2'b01) begin
                        rd_q.push_back('{start + k + 1, rpat(start + k)});
                    end else begin
                        wr_q.push_back('{start + k, wpat(wr_exp)});
                        wr_exp++;
                    end
                end
                last_final = start + half - 1;
                bus_free = start + half;
                finals.push_back(last_final);
                done_q.push_back(last_final + ((rw == 2'b01) ? 2 : 1));
            end
        end
        tick();
        cas_rdy = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int k;
        k = 0;
        while ((rd_q.size() != 0 || wr_q.size() != 0 || done_q.size() != 0 || busy !== 1'b0) && k < limit) begin
            tick(); k++;
        end
        checks++;
        if (k >= limit) begin
            errors++;
            $display("FAIL drain_timeout: outstanding rd %0d wr %0d done %0d busy %b, required all 0", rd_q.size(), wr_q.size(), done_q.size(), busy);
        end
        run(3);
    endtask

    task automatic check_flags(input string name);
        checks++;
        if (bus_err !== exp_berr || cmd_ovf !== exp_ovf) begin
            errors++;
            $display("FAIL %s_flags: bus_err %b cmd_ovf %b, required %b %b", name, bus_err, cmd_ovf, exp_berr, exp_ovf);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_model();
        run(2);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_model();
        run(2);
        checks++;
        if ({dq_oe, wr_ack, rd_valid, rw_done, busy, cmd_ovf, bus_err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: oe/ack/rv/done/busy/ovf/err %b, required 0000000", {dq_oe, wr_ack, rd_valid, rw_done, busy, cmd_ovf, bus_err});
        end
        checks++;
        if (dq_out !== '0 || rd_data !== '0) begin
            errors++; $display("FAIL reset_data: dq_out %h rd_data %h, required 0 0", dq_out, rd_data);
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: busy %b after release, required 0", busy);
        end
    endtask

    task automatic test_read_single();
        do_reset();
        issue(2'b01, 11, 8);
        wait_idle(60);
        check_flags("read_single");
    endtask

    task automatic test_write_single();
        int  t0;
        logic exp_busy;
        do_reset();
        t0 = cyc;
        issue(2'b10, 9, 8);
        for (int k = 0; k < 14; k++) begin
            exp_busy = (cyc - t0 >= 1) && (cyc - t0 <= 12);
            checks++;
            if (busy !== exp_busy) begin
                errors++; $display("FAIL write_busy: cycle %0d busy %b, required %b", cyc - t0, busy, exp_busy);
            end
            tick();
        end
        wait_idle(40);
        check_flags("write_single");
    endtask

    task automatic test_back_to_back();
        do_reset();
        issue(2'b01, 11, 8);
        run(3);
        issue(2'b01, 11, 8);
        wait_idle(60);
        check_flags("gapless");
    endtask

    task automatic test_conflict();
        do_reset();
        issue(2'b01, 11, 8);
        run(1);
        issue(2'b01, 11, 8);
        wait_idle(60);
        check_flags("conflict");
    endtask

    task automatic test_overflow();
        int base;
        do_reset();
        base = rd_seen;
        for (int i = 0; i < 5; i++) begin
            issue(2'b01, 31, 8);
            if (i < 4) run(3);
        end
        wait_idle(120);
        check_flags("overflow");
        checks++;
        if (rd_seen - base != 16) begin
            errors++; $display("FAIL overflow_beats: %0d rd_valid cycles, required 16", rd_seen - base);
        end
    endtask

    task automatic test_mixed();
        do_reset();
        issue(2'b10, 5, 4);
        issue(2'b01, 7, 4);
        wait_idle(40);
        issue(2'b00, 3, 8);
        issue(2'b11, 3, 8);
        checks++;
        if (busy !== 1'b0 || cmd_ovf !== 1'b0) begin
            errors++; $display("FAIL illegal_cmd: busy %b cmd_ovf %b, required 0 0", busy, cmd_ovf);
        end
        issue(2'b10, 2, 4);
        run(2);
        issue(2'b10, 2, 4);
        wait_idle(40);
        check_flags("mixed");
    endtask

    task automatic test_latch();
        do_reset();
        issue(2'b01, 6, 4);
        CL = 5'd20; BL = 5'd8; CWL = 5'd30;
        wait_idle(60);
        check_flags("latch");
    endtask

    task automatic test_reset_mid();
        do_reset();
        issue(2'b10, 4, 8);
        run(4);
        checks++;
        if (dq_oe !== 1'b1) begin
            errors++; $display("FAIL mid_pre: dq_oe %b on second beat, required 1", dq_oe);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (dq_oe !== 1'b0 || wr_ack !== 1'b0 || dq_out !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_abort: dq_oe %b wr_ack %b dq_out %h busy %b, required 0 0 0 0", dq_oe, wr_ack, dq_out, busy);
        end
        clear_model();
        tick();
        reset_n = 1'b1;
        run(6);
        issue(2'b10, 3, 4);
        wait_idle(30);
        check_flags("reset_mid");
    endtask

    initial begin
        cyc = 0; errors = 0; checks = 0; rd_seen = 0;
        clear_model();
        test_reset();
        test_read_single();
        test_write_single();
        test_back_to_back();
        test_conflict();
        test_overflow();
        test_mixed();
        test_latch();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
